// File: rtl/alu01.sv
`default_nettype none
// ============================================================================
// Module   : alu01
// Brief    : 8-bit unsigned ALU with a registered 9-bit result and valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu01 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [8:0] alu_out,
    output logic       out_valid
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_NAND = 4'b0101;
    localparam logic [3:0] c_OP_NOR  = 4'b0110;
    localparam logic [3:0] c_OP_XNOR = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1000;
    localparam logic [3:0] c_OP_SHL  = 4'b1001;
    localparam logic [3:0] c_OP_SHR  = 4'b1010;
    localparam logic [3:0] c_OP_INC  = 4'b1011;

    logic [8:0] w_a_ext;
    logic [8:0] w_b_ext;
    logic [8:0] w_result;
    logic [8:0] r_alu_out;
    logic       r_out_valid;

    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};

    // 9-bit subtraction leaves the borrow in bit 8 (set exactly when a < b).
    always_comb begin
        w_result = 9'h000;
        case (op)
            c_OP_ADD:  w_result = w_a_ext + w_b_ext;
            c_OP_SUB:  w_result = w_a_ext - w_b_ext;
            c_OP_AND:  w_result = {1'b0, a & b};
            c_OP_OR:   w_result = {1'b0, a | b};
            c_OP_XOR:  w_result = {1'b0, a ^ b};
            c_OP_NAND: w_result = {1'b0, ~(a & b)};
            c_OP_NOR:  w_result = {1'b0, ~(a | b)};
            c_OP_XNOR: w_result = {1'b0, ~(a ^ b)};
            c_OP_NOT:  w_result = {1'b0, ~a};
            c_OP_SHL:  w_result = {a, 1'b0};
            c_OP_SHR:  w_result = {2'b00, a[7:1]};
            c_OP_INC:  w_result = w_a_ext + 9'd1;
            default:   w_result = 9'h000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out   <= 9'h000;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out <= w_result;
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu01.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu01
// Brief    : Directed self-checking bench for alu01.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu01;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [8:0] alu_out;
    logic       out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    alu01 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .alu_out   (alu_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    endtask

    // Drive a transaction, let one rising edge capture it, then look 1 time unit later.
    task automatic step(input logic v, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    logic [8:0] exp_tab [12];
    logic [8:0] held;

    initial begin
        exp_tab = '{9'h115, 9'h1C1, 9'h02A, 9'h0EB, 9'h0C1, 9'h0D5,
                    9'h014, 9'h03E, 9'h094, 9'h0D6, 9'h035, 9'h06C};

        rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 4'h0;
        #1;
        check("reset_out",   alu_out,   9'h000);
        check("reset_valid", {8'h0, out_valid}, 9'h000);

        // in_valid ignored while reset is held across an edge
        step(1'b1, 4'h0, 8'h12, 8'h34);
        check("rst_ignore_out",   alu_out,   9'h000);
        check("rst_ignore_valid", {8'h0, out_valid}, 9'h000);

        @(negedge clk);
        rst_n = 1'b1;

        // All defined ops back to back with a=0x6B, b=0xAA
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i), 8'h6B, 8'hAA);
            check($sformatf("op%0d_out", i), alu_out, exp_tab[i]);
            check($sformatf("op%0d_valid", i), {8'h0, out_valid}, 9'h001);
        end

        step(1'b1, 4'b0000, 8'hFF, 8'hFF); check("add_ff_ff", alu_out, 9'h1FE);
        step(1'b1, 4'b0001, 8'h00, 8'h01); check("sub_0_1",   alu_out, 9'h1FF);
        step(1'b1, 4'b0001, 8'h05, 8'h05); check("sub_5_5",   alu_out, 9'h000);
        step(1'b1, 4'b1011, 8'hFF, 8'h00); check("inc_ff",    alu_out, 9'h100);
        step(1'b1, 4'b1001, 8'h80, 8'h00); check("shl_80",    alu_out, 9'h100);
        step(1'b1, 4'b1010, 8'h81, 8'h55); check("shr_81",    alu_out, 9'h040);
        step(1'b1, 4'b1000, 8'h0F, 8'hFF); check("not_0f",    alu_out, 9'h0F0);

        // Reserved ops: preload a nonzero result so a zero is meaningful
        for (int i = 12; i < 16; i++) begin
            step(1'b1, 4'b0000, 8'hF0, 8'h11);
            step(1'b1, 4'(i), 8'hC3, 8'h5A);
            check($sformatf("rsvd%0d_out", i), alu_out, 9'h000);
            check($sformatf("rsvd%0d_valid", i), {8'h0, out_valid}, 9'h001);
        end

        // Hold: result stays while inputs toggle with in_valid low
        step(1'b1, 4'b0100, 8'h3C, 8'h0F);
        held = 9'h033;
        check("hold_load", alu_out, held);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'(i * 5), 8'(8'hA5 ^ i), 8'(8'h5A + i));
            check($sformatf("hold%0d_out", i), alu_out, held);
            check($sformatf("hold%0d_valid", i), {8'h0, out_valid}, 9'h000);
        end

        // Asynchronous reset between edges after an ADD result
        step(1'b1, 4'b0000, 8'h40, 8'h02);
        check("pre_rst_add", alu_out, 9'h042);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out",   alu_out,   9'h000);
        check("async_rst_valid", {8'h0, out_valid}, 9'h000);

        // Release between edges; first rising edge captures 1+2
        in_valid = 1'b1; op = 4'b0000; a = 8'h01; b = 8'h02;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_out",   alu_out,   9'h003);
        check("post_rst_valid", {8'h0, out_valid}, 9'h001);
        @(posedge clk);
        #1;
        check("post_rst_drop", {8'h0, out_valid}, 9'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu01.md
ALU01 -- requirements
Module: alu01

Interface
- REQ-001: clk, input, 1 bit, sole clock; all state SHALL update on its rising edge.
- REQ-002: rst_n, input, 1 bit, reset; it SHALL be asynchronous and active-low.
- REQ-003: in_valid, input, 1 bit, qualifies a/b/op for capture on the current clk edge.
- REQ-004: a, input, 8 bits, operand A, unsigned.
- REQ-005: b, input, 8 bits, operand B, unsigned.
- REQ-006: op, input, 4 bits, operation select.
- REQ-007: alu_out, output, 9 bits, registered result; bit 8 is carry/borrow/shift-out.
- REQ-008: out_valid, output, 1 bit, high for exactly the cycle(s) after a captured in_valid.
- REQ-009: There SHALL be no parameters.

Function
- REQ-010: On a rising clk edge with in_valid=1, alu_out SHALL load f(op,a,b) and out_valid SHALL be 1; latency is exactly 1 cycle.
- REQ-011: On a rising clk edge with in_valid=0, alu_out SHALL hold its value and out_valid SHALL be 0.
- REQ-012: op=0000 ADD: alu_out SHALL be a+b as a 9-bit sum; bit 8 is the carry.
- REQ-013: op=0001 SUB: alu_out SHALL be (a-b) mod 512 as 9-bit two's complement; bit 8=1 iff a<b (borrow).
- REQ-014: op=0010 AND: alu_out SHALL be {0, a&b}.
- REQ-015: op=0011 OR: alu_out SHALL be {0, a|b}.
- REQ-016: op=0100 XOR: alu_out SHALL be {0, a^b}.
- REQ-017: op=0101 NAND: alu_out SHALL be {0, ~(a&b)}.
- REQ-018: op=0110 NOR: alu_out SHALL be {0, ~(a|b)}.
- REQ-019: op=0111 XNOR: alu_out SHALL be {0, ~(a^b)}.
- REQ-020: op=1000 NOT: alu_out SHALL be {0, ~a}; b is ignored.
- REQ-021: op=1001 SHL: alu_out SHALL be {a, 1'b0}, so bit 8 = a[7]; b is ignored.
- REQ-022: op=1010 SHR: alu_out SHALL be {2'b00, a[7:1]}; b is ignored.
- REQ-023: op=1011 INC: alu_out SHALL be a+1 as 9 bits; a=0xFF yields 0x100; b is ignored.
- REQ-024: op=1100..1111 are reserved and SHALL yield alu_out=0x000 with out_valid asserted normally.
- REQ-025: All arithmetic SHALL be unsigned 9-bit; there SHALL be no overflow flag and no saturation.
- REQ-026: The result SHALL depend only on the a, b and op values sampled at the capturing edge; changes between edges SHALL have no effect on outputs.
- REQ-027: Back-to-back in_valid SHALL produce one result per cycle with no bubbles.

Reset
- REQ-028: When rst_n=0, alu_out SHALL be 0x000 and out_valid SHALL be 0 immediately, independent of clk.
- REQ-029: While rst_n=0, in_valid SHALL be ignored.
- REQ-030: The first capture SHALL occur on the first rising clk edge with rst_n=1 and in_valid=1.
- REQ-031: Reset asserted mid-stream SHALL discard any result not yet presented.

Verification
- REQ-032: With a=0x6B, b=0xAA and in_valid=1, stepping op through 0000..1011 over consecutive cycles SHALL produce, one cycle later each, alu_out = 0x115, 0x1C1, 0x02A, 0x0EB, 0x0C1, 0x0D5, 0x014, 0x03E, 0x094, 0x0D6, 0x035, 0x06C.
- REQ-033: Boundary arithmetic SHALL give these results:
  - ADD 0xFF+0xFF -> 0x1FE.
  - SUB 0x00-0x01 -> 0x1FF.
  - SUB 0x05-0x05 -> 0x000.
  - INC 0xFF -> 0x100.
  - SHL 0x80 -> 0x100.
- REQ-034: op=1100..1111 with any a/b SHALL give alu_out=0x000 and out_valid=1.
- REQ-035: With in_valid=0 for 3 cycles while a, b and op toggle, alu_out SHALL hold its previous value and out_valid SHALL stay 0.
- REQ-036: Asserting rst_n=0 between clk edges after an ADD result SHALL drive alu_out=0x000 and out_valid=0 before the next edge.
- REQ-037: Deasserting rst_n with in_valid=1 and op=ADD, a=1, b=2 SHALL give alu_out=0x003 one cycle after the first post-reset edge.
